// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the arbiter and the shared fifo.
// The arbiter drives write enable/data; the fifo answers with full and delayed wrdone.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_wren;
  logic [DATA_WIDTH-1:0] fifo_wrdata;
  logic                  fifo_wrdone;
  logic                  fifo_full;

  modport master (output fifo_wren, fifo_wrdata, input fifo_wrdone, fifo_full);
  modport slave  (input fifo_wren, fifo_wrdata, output fifo_wrdone, fifo_full);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ requesters.
// Tracks each in-flight write by a tag pipeline so wrdone routes back; rejected writes are retried.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int WR_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            done,
  output logic [15:0]                   retry_count,
  fifo_wr_arbiter_if.master             fifo
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         pend, pend_nxt, elig, done_nxt;
  logic [IW-1:0]              ptr, gnt_idx, cand, t_idx;
  logic                       gnt_vld, issue, t_vld, retry_inc;
  logic [DATA_WIDTH-1:0]      sel_data, wrdata_q;
  logic                       wren_q;
  // Stage 0 lines up with the fifo_wren cycle, stage WR_LAT with its fifo_wrdone cycle.
  logic [WR_LAT:0]            vld_pipe;
  logic [WR_LAT:0][IW-1:0]    idx_pipe;

  assign fifo.fifo_wren   = wren_q;
  assign fifo.fifo_wrdata = wrdata_q;

  // A requester whose done is high this cycle counts as free, so a held
  // request is re-granted on the edge where done falls.
  always_comb begin
    elig    = req & ~(pend & ~done);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign issue = gnt_vld & ~fifo.fifo_full;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == IW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign t_vld = vld_pipe[WR_LAT];
  assign t_idx = idx_pipe[WR_LAT];

  // wrdone with no valid tag behind it is dropped.
  always_comb begin
    pend_nxt  = pend & ~done;
    done_nxt  = '0;
    retry_inc = 1'b0;
    if (t_vld) begin
      if (fifo.fifo_wrdone) begin
        done_nxt[t_idx] = 1'b1;
      end else begin
        pend_nxt[t_idx] = 1'b0;
        retry_inc       = 1'b1;
      end
    end
    if (issue) pend_nxt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wren_q      <= 1'b0;
      wrdata_q    <= '0;
      done        <= '0;
      pend        <= '0;
      ptr         <= '0;
      retry_count <= '0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
    end else begin
      wren_q   <= issue;
      pend     <= pend_nxt;
      done     <= done_nxt;
      vld_pipe <= {vld_pipe[WR_LAT-1:0], issue};
      idx_pipe <= {idx_pipe[WR_LAT-1:0], gnt_idx};
      if (issue) begin
        wrdata_q <= sel_data;
        ptr      <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (retry_inc && retry_count != 16'hFFFF)
        retry_count <= retry_count + 16'd1;
    end
  end
endmodule
